opb_register_bank_simulink2ppc: RTL and testbench

Parametrised successor to the single-word Simulink-to-PPC OPB register. Exposes `N_REGS` user words to the PowerPC over OPB, with a live mode and an atomic snapshot mode. Snapshots are triggered from fabric or software, and snapshot/overflow status is kept for software polling. It sits on the ROACH OPB bus beside the other `opb_*` peripherals; all user data is already in the `OPB_Clk` domain.

---
 rtl/opb_reg_bank_pkg.sv | 20 ++
 rtl/opb_slave_ack_fsm.sv | 62 ++++++
 rtl/opb_register_bank_simulink2ppc.sv | 111 +++++++++++
 tb/tb_opb_register_bank_simulink2ppc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/opb_reg_bank_pkg.sv
// Shared definitions for the OPB register bank: word offsets, CTRL bit
// positions and the slave handshake state encoding.
package opb_reg_bank_pkg;

   localparam logic [5:0] W_CTRL     = 6'd0;
   localparam logic [5:0] W_SNAP_CNT = 6'd1;
   localparam logic [5:0] W_CH_BASE  = 6'd2;

   localparam int CTRL_SNAP   = 0;
   localparam int CTRL_MODE   = 1;
   localparam int CTRL_UNREAD = 8;
   localparam int CTRL_OVF    = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_HOLD = 2'd2
   } opb_state_e;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Generic OPB slave handshake: address window decode, IDLE/ACK/HOLD sequencing,
// one-cycle xferAck and read data that is zero whenever no ack is driven.
module opb_slave_ack_fsm
   import opb_reg_bank_pkg::*;
#(
   parameter int                AWIDTH   = 32,
   parameter int                DWIDTH   = 32,
   parameter logic [AWIDTH-1:0] BASEADDR = '0,
   parameter logic [AWIDTH-1:0] HIGHADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AWIDTH-1:0] abus,
   input  logic              select,
   input  logic              rnw,
   input  logic [DWIDTH-1:0] rd_data,
   output logic              accept,
   output logic [5:0]        word_idx,
   output logic              xfer_ack,
   output logic [DWIDTH-1:0] dbus
);

   opb_state_e state;
   logic       hit;
   logic [7:0] offset;
   logic       unused_ofs;

   assign hit        = (abus >= BASEADDR) && (abus <= HIGHADDR);
   assign offset     = abus[7:0] - BASEADDR[7:0];
   assign word_idx   = offset[7:2];
   assign unused_ofs = ^offset[1:0];
   assign accept     = (state == ST_IDLE) && select && hit;

   // Read data is latched on the accept edge so a later capture cannot disturb it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         xfer_ack <= 1'b0;
         dbus     <= '0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               state    <= ST_ACK;
               xfer_ack <= 1'b1;
               dbus     <= rnw ? rd_data : '0;
            end
            ST_ACK: begin
               state    <= ST_HOLD;
               xfer_ack <= 1'b0;
               dbus     <= '0;
            end
            ST_HOLD: if (!select) state <= ST_IDLE;
            default: begin
               state    <= ST_IDLE;
               xfer_ack <= 1'b0;
               dbus     <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// N_REGS fabric words exposed to the PowerPC over OPB, readable live or from
// an atomically captured shadow copy, with capture count and overflow status.
module opb_register_bank_simulink2ppc
   import opb_reg_bank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h01080000,
   parameter logic [31:0] C_HIGHADDR   = 32'h010800FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex5",
   parameter int          N_REGS       = 4
) (
   input  logic                           OPB_Clk,
   input  logic                           OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]        OPB_ABus,
   input  logic [0:3]                     OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]        OPB_DBus,
   input  logic                           OPB_RNW,
   input  logic                           OPB_select,
   input  logic                           OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]        Sl_DBus,
   output logic                           Sl_xferAck,
   output logic                           Sl_errAck,
   output logic                           Sl_retry,
   output logic                           Sl_toutSup,
   input  logic [N_REGS*C_OPB_DWIDTH-1:0] user_data_in,
   input  logic                           user_snap
);

   localparam logic [5:0] W_LAST = 6'(W_CH_BASE + N_REGS - 1);

   logic [C_OPB_AWIDTH-1:0]             addr;
   logic [C_OPB_DWIDTH-1:0]             wdata, rd_data, fsm_dbus;
   logic [N_REGS-1:0][C_OPB_DWIDTH-1:0] live_q, shadow;
   logic [C_OPB_DWIDTH-1:0]             snap_cnt;
   logic [5:0]                          word_idx;
   logic accept, xfer_ack, mode, unread, ovf;
   logic wr_ctrl, capture, rd_last, unused_in;

   assign addr      = OPB_ABus;
   assign wdata     = OPB_DBus;
   assign unused_in = ^{OPB_seqAddr, OPB_BE[0:2], wdata[C_OPB_DWIDTH-1:2]};

   opb_slave_ack_fsm #(
      .AWIDTH   (C_OPB_AWIDTH),
      .DWIDTH   (C_OPB_DWIDTH),
      .BASEADDR (C_BASEADDR),
      .HIGHADDR (C_HIGHADDR)
   ) u_fsm (
      .clk      (OPB_Clk),
      .rst_n    (OPB_Rst),
      .abus     (addr),
      .select   (OPB_select),
      .rnw      (OPB_RNW),
      .rd_data  (rd_data),
      .accept   (accept),
      .word_idx (word_idx),
      .xfer_ack (xfer_ack),
      .dbus     (fsm_dbus)
   );

   assign Sl_DBus    = fsm_dbus;
   assign Sl_xferAck = xfer_ack;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   // Only the LSB byte lane carries CTRL's writable bits.
   assign wr_ctrl = accept && !OPB_RNW && (word_idx == W_CTRL) && OPB_BE[3];
   assign capture = user_snap || (wr_ctrl && wdata[CTRL_SNAP]);
   assign rd_last = accept && OPB_RNW && (word_idx == W_LAST);

   always_comb begin
      rd_data = '0;
      if (word_idx == W_CTRL) begin
         rd_data[CTRL_MODE]   = mode;
         rd_data[CTRL_UNREAD] = unread;
         rd_data[CTRL_OVF]    = ovf;
      end else if (word_idx == W_SNAP_CNT) begin
         rd_data = snap_cnt;
      end else begin
         for (int i = 0; i < N_REGS; i++)
            if (word_idx == 6'(W_CH_BASE + i))
               rd_data = mode ? shadow[i] : live_q[i];
      end
   end

   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst) begin
         live_q   <= '0;
         shadow   <= '0;
         snap_cnt <= '0;
         mode     <= 1'b0;
         unread   <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         live_q <= user_data_in;
         if (wr_ctrl) mode <= wdata[CTRL_MODE];
         // A capture beats a coincident last-channel read so no data goes unseen.
         if (capture) begin
            shadow   <= user_data_in;
            snap_cnt <= snap_cnt + 1'b1;
            unread   <= 1'b1;
            if (unread) ovf <= 1'b1;
         end else if (rd_last) begin
            unread <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Directed bench for the OPB register bank: a vector table for plain register
// accesses plus hand sequences for capture, overflow, wrap and reset abort.
module tb_opb_register_bank_simulink2ppc;
   import opb_reg_bank_pkg::*;

   localparam logic [31:0] BASE = 32'h01080000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [0:31]  abus, dbus_in, sl_dbus;
   logic [0:3]   be;
   logic         rnw, sel, seq, ack, err_ack, retry, tout_sup, user_snap;
   logic [127:0] udata;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   opb_register_bank_simulink2ppc dut (
      .OPB_Clk      (clk),
      .OPB_Rst      (rst_n),
      .OPB_ABus     (abus),
      .OPB_BE       (be),
      .OPB_DBus     (dbus_in),
      .OPB_RNW      (rnw),
      .OPB_select   (sel),
      .OPB_seqAddr  (seq),
      .Sl_DBus      (sl_dbus),
      .Sl_xferAck   (ack),
      .Sl_errAck    (err_ack),
      .Sl_retry     (retry),
      .Sl_toutSup   (tout_sup),
      .user_data_in (udata),
      .user_snap    (user_snap)
   );

   typedef struct {
      logic [31:0] addr;
      logic        rnw;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One transfer; select is dropped right after the ack, then 3 more cycles watched.
   task automatic xfer(input logic [31:0] addr, input logic r, input logic [31:0] wd,
                       input logic [3:0] b, input logic snap,
                       output logic [31:0] rd, output int acks, output logic leak);
      @(negedge clk);
      abus = addr; rnw = r; dbus_in = wd; be = b; sel = 1'b1; user_snap = snap;
      @(posedge clk); #1;
      rd = sl_dbus;
      acks = ack ? 1 : 0;
      leak = 1'b0;
      sel = 1'b0; user_snap = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (ack) acks++;
         if (!ack && sl_dbus != 32'h0) leak = 1'b1;
      end
   endtask

   task automatic do_xfer(input string name, input logic [31:0] addr, input logic r,
                          input logic [31:0] wd, input logic [3:0] b, input logic snap,
                          input logic [31:0] exp);
      logic [31:0] rd;
      int          acks;
      logic        leak;
      xfer(addr, r, wd, b, snap, rd, acks, leak);
      check(name, rd, exp);
      check({name, "_acks"}, 32'(acks), 32'd1);
      check({name, "_dbus_idle"}, {31'b0, leak}, 32'd0);
   endtask

   task automatic rd(input string name, input logic [7:0] ofs, input logic [31:0] exp);
      do_xfer(name, BASE + 32'(ofs), 1'b1, 32'h0, 4'b1111, 1'b0, exp);
   endtask

   task automatic pulse_snap();
      @(negedge clk); user_snap = 1'b1;
      @(negedge clk); user_snap = 1'b0;
   endtask

   initial begin
      // Register access table, run in order after reset.
      vt[0]  = '{BASE + 32'h00, 1'b1, 32'h0,    4'b1111, 32'h0};
      vt[1]  = '{BASE + 32'h04, 1'b1, 32'h0,    4'b1111, 32'h0};
      vt[2]  = '{BASE + 32'h10, 1'b1, 32'h0,    4'b1111, 32'hDEADBEEF};
      vt[3]  = '{BASE + 32'h08, 1'b1, 32'h0,    4'b1111, 32'h11111111};
      vt[4]  = '{BASE + 32'hFC, 1'b1, 32'h0,    4'b1111, 32'h0};
      vt[5]  = '{BASE + 32'h18, 1'b1, 32'h0,    4'b1111, 32'h0};
      vt[6]  = '{BASE + 32'h00, 1'b0, 32'h2,    4'b1111, 32'h0};
      vt[7]  = '{BASE + 32'h00, 1'b1, 32'h0,    4'b1111, 32'h2};
      vt[8]  = '{BASE + 32'h00, 1'b0, 32'h0,    4'b1110, 32'h0};
      vt[9]  = '{BASE + 32'h00, 1'b1, 32'h0,    4'b1111, 32'h2};
      vt[10] = '{BASE + 32'h04, 1'b0, 32'h1234, 4'b1111, 32'h0};
      vt[11] = '{BASE + 32'h04, 1'b1, 32'h0,    4'b1111, 32'h0};

      rst_n = 1'b0; abus = '0; dbus_in = '0; be = '0; rnw = 1'b1; sel = 1'b0;
      seq = 1'b0; user_snap = 1'b0;
      udata = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", {31'b0, ack}, 32'd0);
      check("rst_dbus", sl_dbus, 32'h0);
      check("tied_outs", {29'b0, err_ack, retry, tout_sup}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Miss outside the window: no ack.
      begin
         logic [31:0] r; int a; logic l;
         xfer(32'h01080100, 1'b1, 32'h0, 4'b1111, 1'b0, r, a, l);
         check("miss_acks", 32'(a), 32'd0);
      end

      // Select sampled at T must produce the ack at T+1.
      begin
         logic [31:0] r; int a; logic l;
         @(negedge clk);
         abus = BASE + 32'h10; rnw = 1'b1; sel = 1'b1;
         @(posedge clk); #1;
         check("lat_ack_t1", {31'b0, ack}, 32'd1);
         check("lat_data_t1", sl_dbus, 32'hDEADBEEF);
         sel = 1'b0;
         @(posedge clk); #1;
         check("lat_ack_t2", {31'b0, ack}, 32'd0);
         check("lat_data_t2", sl_dbus, 32'h0);
         repeat (2) @(posedge clk);
      end

      for (int i = 0; i < 12; i++)
         do_xfer($sformatf("vec%0d", i), vt[i].addr, vt[i].rnw, vt[i].wd, vt[i].be, 1'b0, vt[i].exp);

      // Snapshot mode: shadow holds the value present with the strobe.
      pulse_snap();
      udata[31:0] = 32'hAAAAAAAA;
      rd("snap_ch0", 8'h08, 32'h11111111);
      rd("snap_cnt1", 8'h04, 32'd1);
      rd("snap_ctrl1", 8'h00, 32'h102);

      // Second capture with UNREAD set -> OVF; last-channel read clears UNREAD only.
      pulse_snap();
      rd("ovf_ctrl", 8'h00, 32'h302);
      rd("ovf_ch0", 8'h08, 32'hAAAAAAAA);
      rd("ovf_last", 8'h14, 32'h44444444);
      rd("ovf_ctrl_clr", 8'h00, 32'h202);

      // SW snap and fabric snap together count once.
      do_xfer("dual_wr", BASE, 1'b0, 32'h3, 4'b1111, 1'b1, 32'h0);
      rd("dual_cnt", 8'h04, 32'd3);
      rd("dual_ctrl", 8'h00, 32'h302);

      // A capture coincident with a read does not change the in-flight data.
      do_xfer("inflight", BASE + 32'h04, 1'b1, 32'h0, 4'b1111, 1'b1, 32'd3);
      rd("inflight_after", 8'h04, 32'd4);

      // Last-channel read vs capture in the same cycle: UNREAD stays set.
      do_xfer("race_last", BASE + 32'h14, 1'b1, 32'h0, 4'b1111, 1'b1, 32'h44444444);
      rd("race_ctrl", 8'h00, 32'h302);
      rd("race_cnt", 8'h04, 32'd5);

      // Counter wrap.
      @(negedge clk); force dut.snap_cnt = 32'hFFFFFFFF;
      @(negedge clk); release dut.snap_cnt;
      rd("wrap_pre", 8'h04, 32'hFFFFFFFF);
      pulse_snap();
      rd("wrap_post", 8'h04, 32'h0);

      // Back to live mode: channel reads follow the registered inputs.
      do_xfer("live_wr", BASE, 1'b0, 32'h0, 4'b1111, 1'b0, 32'h0);
      @(negedge clk);
      udata[31:0]  = 32'h55555555;
      udata[95:64] = 32'h12345678;
      rd("live_ch0", 8'h08, 32'h55555555);
      rd("live_ch2", 8'h10, 32'h12345678);

      // Reset during ACK aborts the transfer and leaves the FSM idle.
      @(negedge clk);
      abus = BASE; rnw = 1'b1; sel = 1'b1;
      @(posedge clk); #1;
      check("abort_ack_before", {31'b0, ack}, 32'd1);
      rst_n = 1'b0; sel = 1'b0;
      @(posedge clk); #1;
      check("abort_ack", {31'b0, ack}, 32'd0);
      check("abort_dbus", sl_dbus, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_state", 32'(dut.u_fsm.state), 32'(ST_IDLE));
      check("abort_ack_after", {31'b0, ack}, 32'd0);
      rd("post_rst_ctrl", 8'h00, 32'h0);
      rd("post_rst_cnt", 8'h04, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
